// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_if
// Description : Keypad-side and key-event signals of the keypad scanner.
//               master : the scanner (drives columns and key outputs,
//                        reads rows)
//               slave  : the keypad / key consumer side
//   row       [3:0] keypad rows, active-low, pulled up externally
//   col       [3:0] keypad columns, active-low one-hot
//   key_code  [3:0] hex value of the last accepted key
//   key_valid       one-clock pulse per accepted key
//   key_down        level, high while an accepted single key is held
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 keypad scanner. Drives the columns low one at a time,
//               samples the synchronized rows at the end of each column
//               slot, classifies every full scan as no key / one key /
//               several keys, and debounces that classification over
//               DEBOUNCE_SCANS identical scans before reporting a key.
//   clock  : system clock
//   reset  : asynchronous, active-low, clears all state
//   kp     : keypad_scanner_if.master (row in; col, key_code, key_valid,
//            key_down out)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input wire              clock,
    input wire              reset,
    keypad_scanner_if.master kp
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEB_MAX  = c_CNT_W'(DEBOUNCE_SCANS);

    // Key value at index {column, row}.
    localparam logic [3:0] c_KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_t;

    // The code field is forced to zero unless the kind is RES_KEY, so a
    // plain equality compare is a correct "same scan result" test.
    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] code;
    } scan_res_t;

    localparam scan_res_t c_RES_NONE = '{kind: RES_NONE, code: 4'h0};

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_idx;
    logic [1:0]         r_acc_cnt;   // pressed points so far, saturates at 2
    logic [3:0]         r_acc_code;
    scan_res_t          r_pend;
    scan_res_t          r_stable;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_evt_key;
    logic               r_evt_clear;
    logic [3:0]         r_evt_code;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_key_down;

    logic               w_tick;
    logic               w_scan_end;
    logic [3:0]         w_pressed;
    logic [2:0]         w_hits;
    logic [3:0]         w_col_code;
    logic [2:0]         w_sum;
    logic [1:0]         w_total;
    logic [3:0]         w_code;
    scan_res_t          w_res;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_accept;

    assign w_tick     = (r_div == c_DIV_LAST);
    assign w_scan_end = w_tick && (r_idx == 2'd3);
    assign w_pressed  = ~r_row_sync;

    // Classify the current column and fold it into the running scan.
    always_comb begin
        w_hits     = {2'b00, w_pressed[0]} + {2'b00, w_pressed[1]}
                   + {2'b00, w_pressed[2]} + {2'b00, w_pressed[3]};
        w_col_code = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            if (w_pressed[r]) begin
                w_col_code = c_KEY_MAP[{r_idx, 2'(r)}];
            end
        end
        w_sum   = {1'b0, r_acc_cnt} + w_hits;
        w_total = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_code  = (r_acc_cnt == 2'd0) ? w_col_code : r_acc_code;

        w_res = c_RES_NONE;
        if (w_total == 2'd1) begin
            w_res.kind = RES_KEY;
            w_res.code = w_code;
        end else if (w_total == 2'd2) begin
            w_res.kind = RES_MULTI;
        end
    end

    // Debounce decision for the scan that ends on this tick.
    always_comb begin
        if (w_res == r_pend) begin
            w_cnt_next = (r_cnt == c_DEB_MAX) ? r_cnt : r_cnt + 1'b1;
        end else begin
            w_cnt_next = c_CNT_W'(1);
        end
        w_accept = (w_cnt_next == c_DEB_MAX) && (w_res != r_stable);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_row_meta  <= 4'b1111;
            r_row_sync  <= 4'b1111;
            r_div       <= '0;
            r_idx       <= 2'd0;
            r_acc_cnt   <= 2'd0;
            r_acc_code  <= 4'h0;
            r_pend      <= c_RES_NONE;
            r_stable    <= c_RES_NONE;
            r_cnt       <= '0;
            r_evt_key   <= 1'b0;
            r_evt_clear <= 1'b0;
            r_evt_code  <= 4'h0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_row_meta <= kp.row;
            r_row_sync <= r_row_meta;

            r_div       <= w_tick ? '0 : r_div + 1'b1;
            r_evt_key   <= 1'b0;
            r_evt_clear <= 1'b0;

            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
                if (w_scan_end) begin
                    r_acc_cnt  <= 2'd0;
                    r_acc_code <= 4'h0;
                    r_pend     <= w_res;
                    r_cnt      <= w_cnt_next;
                    if (w_accept) begin
                        r_stable    <= w_res;
                        r_evt_key   <= (w_res.kind == RES_KEY);
                        r_evt_clear <= (w_res.kind != RES_KEY);
                        r_evt_code  <= w_res.code;
                    end
                end else begin
                    r_acc_cnt  <= w_total;
                    r_acc_code <= w_code;
                end
            end

            // Outputs follow one clock after the accepting tick.
            r_key_valid <= r_evt_key;
            if (r_evt_key) begin
                r_key_code <= r_evt_code;
                r_key_down <= 1'b1;
            end else if (r_evt_clear) begin
                r_key_down <= 1'b0;
            end
        end
    end

    assign kp.col       = ~(4'b0001 << r_idx);
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_down  = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//               DEBOUNCE_SCANS=2). Key sets are held for whole scans; a
//               scan-level reference model predicts the outputs per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int c_SCAN_DIV = 4;
    localparam int c_DEB      = 2;
    localparam int c_SCAN_LEN = 4 * c_SCAN_DIV;
    localparam int c_NONE     = -1;
    localparam int c_MULTI    = 16;
    localparam int c_NOEVT    = -2;

    // Key value at index row*4 + column.
    localparam int c_KEYMAP [16] = '{
        1, 2, 3, 10,
        4, 5, 6, 11,
        7, 8, 9, 12,
        0, 15, 14, 13
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] keys = 16'h0;
    logic [3:0]  w_row;

    int checks = 0;
    int failures = 0;

    // Reference model state (scan level).
    int         m_pend, m_cnt, m_stable, m_evt;
    logic [3:0] m_code;
    logic       m_down;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV       (c_SCAN_DIV),
        .DEBOUNCE_SCANS (c_DEB)
    ) u_dut (
        .clock (clk),
        .reset (reset),
        .kp    (kif.master)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to its column.
    always_comb begin
        w_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (kif.col[c] == 1'b0 && keys[c_KEYMAP[r*4+c]]) begin
                    w_row[r] = 1'b0;
                end
            end
        end
    end
    assign kif.row = w_row;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    function automatic int scan_result(input logic [15:0] m);
        int n;
        int k;
        n = $countones(m);
        k = c_NONE;
        if (n == 1) begin
            for (int i = 0; i < 16; i++) if (m[i]) k = i;
        end else if (n > 1) begin
            k = c_MULTI;
        end
        return k;
    endfunction

    task automatic model_reset();
        m_pend   = c_NONE;
        m_cnt    = 0;
        m_stable = c_NONE;
        m_evt    = c_NOEVT;
        m_code   = 4'h0;
        m_down   = 1'b0;
    endtask

    task automatic model_scan_end(input logic [15:0] m);
        int r;
        r = scan_result(m);
        if (r == m_pend) begin
            m_cnt = (m_cnt + 1 > c_DEB) ? c_DEB : m_cnt + 1;
        end else begin
            m_pend = r;
            m_cnt  = 1;
        end
        if (m_cnt == c_DEB && r != m_stable) begin
            m_stable = r;
            m_evt    = r;
        end else begin
            m_evt = c_NOEVT;
        end
    endtask

    // Called at the negedge of cycle 0 of a scan; leaves at cycle 0 of the
    // next scan (or after ncyc cycles for a truncated scan).
    task automatic run_scan(input logic [15:0] m, input int ncyc);
        logic       exp_valid;
        logic [3:0] exp_col;
        keys = m;
        for (int k = 0; k < ncyc; k++) begin
            exp_valid = 1'b0;
            if (k == 1 && m_evt != c_NOEVT) begin
                if (m_evt >= 0 && m_evt < 16) begin
                    exp_valid = 1'b1;
                    m_code    = 4'(m_evt);
                    m_down    = 1'b1;
                end else begin
                    m_down = 1'b0;
                end
                m_evt = c_NOEVT;
            end
            exp_col = 4'b0001 << (k / c_SCAN_DIV);
            check("col", kif.col, ~exp_col);
            check("key_valid", {3'b000, kif.key_valid}, {3'b000, exp_valid});
            check("key_down", {3'b000, kif.key_down}, {3'b000, m_down});
            check("key_code", kif.key_code, m_code);
            @(negedge clk);
        end
        if (ncyc == c_SCAN_LEN) model_scan_end(m);
    endtask

    task automatic scans(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_scan(m, c_SCAN_LEN);
    endtask

    task automatic check_reset_values();
        check("rst_col", kif.col, 4'b1110);
        check("rst_key_valid", {3'b000, kif.key_valid}, 4'h0);
        check("rst_key_down", {3'b000, kif.key_down}, 4'h0);
        check("rst_key_code", kif.key_code, 4'h0);
    endtask

    function automatic logic [15:0] kbit(input int k);
        logic [15:0] v;
        v = 16'h0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        int          kind;
        int          a;
        int          b;
        int          hold;
        logic [15:0] m;

        model_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b1;   // released at a negedge: this is cycle 0 of scan 0

        // Idle scans: column rotation.
        scans(16'h0, 2);

        // Key 5 held, then released.
        scans(kbit(5), 4);
        scans(16'h0, 2);
        // Press 5 again.
        scans(kbit(5), 3);
        scans(16'h0, 3);

        // Key C bouncing in alternate scans, then steady.
        for (int i = 0; i < 3; i++) begin
            scans(kbit(12), 1);
            scans(16'h0, 1);
        end
        scans(kbit(12), 3);
        scans(16'h0, 3);

        // Keys 1 and 2 together, then release 2.
        scans(kbit(1) | kbit(2), 3);
        scans(kbit(1), 3);
        scans(16'h0, 3);

        // Key E held across a mid-scan reset.
        scans(kbit(14), 3);
        run_scan(kbit(14), 6);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_reset_values();
            @(negedge clk);
        end
        reset = 1'b1;
        model_reset();
        scans(kbit(14), 3);
        scans(16'h0, 3);

        // Random key sets held for random numbers of scans.
        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 15));
            b    = (a + int'($urandom_range(1, 15))) % 16;
            hold = int'($urandom_range(1, 3));
            case (kind)
                0:       m = 16'h0;
                3:       m = kbit(a) | kbit(b);
                default: m = kbit(a);
            endcase
            scans(m, hold);
        end
        scans(16'h0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed seven-segment display path.
- The display path drives anodes in rotation and shows data. This block drives keypad columns in rotation, reads the rows, and produces one debounced hex key code per press.
- Sits next to the debounced buttons and switches. Its key_code/key_valid outputs feed RAM write data and address stepping in the top level.

Parameters:
- SCAN_DIV, 100000, clock cycles each column is driven; 1 ms at 100 MHz; minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a change; minimum 1.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous, active-low; clears all state.
- row, input, 4, keypad rows; active-low (0 = pressed key connects the row to the driven column); pulled up externally.
- col, output, 4, keypad columns; active-low one-hot, exactly one bit 0 at all times.
- key_code, output, 4, hex value of the last accepted key.
- key_valid, output, 1, one-clock pulse when a new key is accepted.
- key_down, output, 1, level; 1 while an accepted single key is held.

Behaviour:
- Reset values (while reset = 0): col = 4'b1110, divider = 0, column index = 0, key_code = 0, key_valid = 0, key_down = 0, stable candidate = NONE, debounce count = 0, row synchronizer = 4'b1111.
- Row synchronizer: two-flop synchronizer on row; all logic uses the synchronized value.
- Divider: counts 0..SCAN_DIV-1 and wraps. tick = 1 when the divider reaches SCAN_DIV-1.
- Column stepping:
  - col = ~(4'b0001 << idx).
  - On tick: sample the synchronized rows for the current column, then idx <= idx+1 mod 4.
  - The column therefore settles for SCAN_DIV-1 cycles before its rows are sampled.
- Scan accumulation:
  - Over one full scan (idx 0..3), count the pressed (row, col) points.
  - Scan result: NONE (0 points), KEY(code) (exactly 1 point), MULTI (2 or more points).
  - The result is evaluated at the tick where idx = 3, then cleared for the next scan.
- Key map (row index 0..3 top to bottom), listed per column:
  - col0: 1, 4, 7, 0
  - col1: 2, 5, 8, F
  - col2: 3, 6, 9, E
  - col3: A, B, C, D
- Debounce at each scan end:
  - If the result equals the pending candidate, the count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise pending <= result and count <= 1.
  - When count reaches DEBOUNCE_SCANS and pending != stable: stable <= pending, and the acceptance action below fires in the same clock.
- Acceptance actions, registered (outputs change on the clock after the scan-end tick):
  - stable becomes KEY(k): key_code <= k, key_down <= 1, key_valid pulses high for exactly one clock. This also applies for KEY(j) -> KEY(k) with no NONE between, which counts as a new press.
  - stable becomes NONE: key_down <= 0, key_code holds, no pulse.
  - stable becomes MULTI: key_down <= 0, key_code holds, no pulse. MULTI is ghost-key protection; a later single key from MULTI does pulse.
- Latency: a clean press present from the start of a scan is accepted 4*SCAN_DIV*DEBOUNCE_SCANS + 1 clocks after that scan begins.
- Bounce: any differing scan restarts the count. A press shorter than DEBOUNCE_SCANS full scans is never reported.
- Held key: no repeat; key_valid fires once per acceptance.
- Reset mid-scan: immediate return to reset values. A key still held after release of reset is reported once after the debounce interval.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; the bench models the keypad as row[r] = 0 iff the key at (r, c) is pressed and col[c] = 0):
- Reset -> col = 4'b1110, key_code = 0, key_valid = 0, key_down = 0. After release, col cycles 1110, 1101, 1011, 0111, each for exactly 4 clocks.
- Press key 5 (row1, col1) continuously -> exactly one key_valid pulse, 33 clocks after the start of the first full scan with the key down; key_code = 5, key_down = 1 until release.
- Press 5, release for 2 scans, press 5 again -> two key_valid pulses, each with key_code = 5. key_down falls 2 scans after release.
- Bounce: key C (row2, col3) present in alternate scans for 6 scans, then steady -> no pulse during bouncing; one pulse with key_code = C after 2 steady scans.
- Press 1 and 2 together -> key_down = 0, no pulse, key_code unchanged. Release 2, keeping 1 -> pulse with key_code = 1.
- Hold key E, assert reset mid-scan for 3 clocks, then release reset -> outputs at reset values during reset. Afterwards one pulse with key_code = E after 2 full scans.
